hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WB_BYPASS, default 1: 1 means RF writes in the first half-cycle, so the WB-stage destination is never a hazard; 0 means it is.
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs  in  5  ID source register 1 (IR[25:21]).
REQ-007 id_rt  in  5  ID source register 2 (IR[20:16]).
REQ-008 id_use_rs, id_use_rt  in  1 each  the instruction reads that source.
REQ-009 id_dst  in  5  ID destination register; 0 = no write.
REQ-010 id_branch  in  1  ID instruction is a branch resolved in EX.
REQ-011 ex_taken  in  1  EX-stage branch outcome.
REQ-012 pc_we  out  1  PC advance enable.
REQ-013 fi_id_we  out  1  FI_ID register load enable.
REQ-014 fi_id_flush  out  1  FI_ID loads a NOP (all-zero word).
REQ-015 id_ex_bubble  out  1  ID_EX loads a NOP instead of ID contents.
REQ-016 state  out  2  RUN=0, STALL=1, BR_WAIT=2, FLUSH=3.
REQ-017 stall_cnt  out  CNT_W  cumulative count of cycles with pc_we=0.

Function
REQ-018 Scoreboard: three registered entries {v, addr} for EX, MA and WB, updated every clock.
REQ-019 Scoreboard shift each clock: WB<=MA, MA<=EX, EX<={issue && id_dst!=0, id_dst}.
REQ-020 hazard is combinational: id_valid && ((id_use_rs && id_rs!=0 && match(id_rs)) || (id_use_rt && id_rt!=0 && match(id_rt))).
REQ-021 match(r): r equals the address of a valid EX or MA entry, or of a valid WB entry when WB_BYPASS=0.
REQ-022 issue = id_valid && !hazard && state is RUN or STALL.
REQ-023 RUN/STALL with hazard: pc_we=0, fi_id_we=0, id_ex_bubble=1; next state STALL.
REQ-024 RUN/STALL, no hazard, issuing a non-branch: pc_we=1, fi_id_we=1, bubble=0; next state RUN.
REQ-025 RUN/STALL, no hazard, issuing a branch: pc_we=1, fi_id_we=1, bubble=0; next state BR_WAIT.
REQ-026 RUN/STALL with id_valid=0: pc_we=1, fi_id_we=1, bubble=1; next state RUN.
REQ-027 BR_WAIT, one cycle: pc_we=0, fi_id_we=0, bubble=1; next state FLUSH if ex_taken=1, otherwise RUN.
REQ-028 FLUSH, one cycle: pc_we=1 (datapath loads target), fi_id_we=1, fi_id_flush=1, bubble=1; next state RUN.
REQ-029 fi_id_flush is 1 only in FLUSH.
REQ-030 ex_taken is ignored outside BR_WAIT.
REQ-031 Hazard has priority over branch: a hazarded branch is not issued and stays in ID.
REQ-032 stall_cnt increments on every clock with pc_we=0 and saturates at all-ones (no wrap).
REQ-033 pc_we, fi_id_we, fi_id_flush and id_ex_bubble are combinational from state, scoreboard and ID inputs; there are no latches.

Reset
REQ-034 While RST_N=0, immediately: state=RUN, all scoreboard v=0, stall_cnt=0.
REQ-035 Resulting outputs with id_valid=0: pc_we=1, fi_id_we=1, fi_id_flush=0, id_ex_bubble=1.
REQ-036 Reset asserted mid-STALL or mid-BR_WAIT aborts it; a pending branch outcome is discarded.
REQ-037 First edge after RST_N rises: normal RUN operation.

Verification
REQ-038 Back-to-back dependency: issue add $3 (dst 3), then a reader of rs=3 -> 2 stall cycles (EX and MA matches) with pc_we=0 and bubble=1, issue on the 3rd cycle, stall_cnt=2. With WB_BYPASS=0 -> 3 stall cycles, stall_cnt=3.
REQ-039 Register zero: dst 0 followed by a reader of rs=0 -> no stall, stall_cnt unchanged.
REQ-040 Taken branch: issue branch, then ex_taken=1 in BR_WAIT -> states RUN, BR_WAIT, FLUSH, RUN; fi_id_flush=1 for exactly 1 cycle; stall_cnt+1.
REQ-041 Untaken branch: ex_taken=0 in BR_WAIT -> BR_WAIT to RUN, fi_id_flush never 1; ex_taken=1 pulsed while in RUN -> no effect.
REQ-042 Hazard plus branch: branch reading rt=5 right after a dst-5 instruction -> STALL for 2 cycles, then BR_WAIT; the branch issues exactly once.
REQ-043 Reset mid-operation and saturation: RST_N=0 during BR_WAIT -> state=0 and stall_cnt=0 before the next edge. With CNT_W=4 and a 20-cycle stall -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ID-stage interlock for a 5-stage pipeline: stalls dependent reads behind
// in-flight writers and sequences the branch wait / flush slots.
module hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_branch,
  input  logic             ex_taken,
  output logic             pc_we,
  output logic             fi_id_we,
  output logic             fi_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    BR_WAIT = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             exV_q, maV_q, wbV_q;
  logic [4:0]       exA_q, maA_q, wbA_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             rs_match, rt_match, hazard, issue;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The WB entry only matters when the register file cannot write-then-read in one cycle.
  always_comb begin
    rs_match = (exV_q && exA_q == id_rs) || (maV_q && maA_q == id_rs) ||
               (!WB_BYPASS && wbV_q && wbA_q == id_rs);
    rt_match = (exV_q && exA_q == id_rt) || (maV_q && maA_q == id_rt) ||
               (!WB_BYPASS && wbV_q && wbA_q == id_rt);
    hazard   = id_valid &&
               ((id_use_rs && id_rs != 5'd0 && rs_match) ||
                (id_use_rt && id_rt != 5'd0 && rt_match));
  end

  always_comb begin
    pc_we        = 1'b1;
    fi_id_we     = 1'b1;
    fi_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    issue        = 1'b0;
    state_d      = RUN;
    case (state_q)
      RUN, STALL: begin
        if (hazard) begin
          pc_we    = 1'b0;
          fi_id_we = 1'b0;
          state_d  = STALL;
        end else if (id_valid) begin
          issue        = 1'b1;
          id_ex_bubble = 1'b0;
          state_d      = id_branch ? BR_WAIT : RUN;
        end
      end
      BR_WAIT: begin
        pc_we    = 1'b0;
        fi_id_we = 1'b0;
        state_d  = ex_taken ? FLUSH : RUN;
      end
      FLUSH: begin
        fi_id_flush = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Scoreboard shifts every clock; non-issuing cycles enter EX as invalid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      exV_q       <= 1'b0;
      maV_q       <= 1'b0;
      wbV_q       <= 1'b0;
      exA_q       <= 5'd0;
      maA_q       <= 5'd0;
      wbA_q       <= 5'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      exV_q   <= issue && (id_dst != 5'd0);
      exA_q   <= id_dst;
      maV_q   <= exV_q;
      maA_q   <= exA_q;
      wbV_q   <= maV_q;
      wbA_q   <= maA_q;
      if (!pc_we && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (default, no WB bypass, 4-bit counter)
// share stimulus; each cycle's expected outputs are queued and then compared.
module tb_hazard_ctrl;

  logic       CLK, RST_N;
  logic       idValid, idUseRs, idUseRt, idBranch, exTaken;
  logic [4:0] idRs, idRt, idDst;

  logic        pcWeDef, fiWeDef, flushDef, bubDef;
  logic [1:0]  stateDef;
  logic [15:0] cntDef;
  logic        pcWeNb, fiWeNb, flushNb, bubNb;
  logic [1:0]  stateNb;
  logic [15:0] cntNb;
  logic        pcWeSat, fiWeSat, flushSat, bubSat;
  logic [1:0]  stateSat;
  logic [3:0]  cntSat;

  typedef struct {
    string      tag;
    int         sel;
    logic [1:0] st;
    logic       pc;
    logic       fi;
    logic       fl;
    logic       bub;
    int         cnt;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl dutDef (
    .CLK(CLK), .RST_N(RST_N), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_dst(idDst), .id_branch(idBranch),
    .ex_taken(exTaken), .pc_we(pcWeDef), .fi_id_we(fiWeDef), .fi_id_flush(flushDef),
    .id_ex_bubble(bubDef), .state(stateDef), .stall_cnt(cntDef)
  );

  hazard_ctrl #(.WB_BYPASS(1'b0)) dutNb (
    .CLK(CLK), .RST_N(RST_N), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_dst(idDst), .id_branch(idBranch),
    .ex_taken(exTaken), .pc_we(pcWeNb), .fi_id_we(fiWeNb), .fi_id_flush(flushNb),
    .id_ex_bubble(bubNb), .state(stateNb), .stall_cnt(cntNb)
  );

  hazard_ctrl #(.CNT_W(4)) dutSat (
    .CLK(CLK), .RST_N(RST_N), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_dst(idDst), .id_branch(idBranch),
    .ex_taken(exTaken), .pc_we(pcWeSat), .fi_id_we(fiWeSat), .fi_id_flush(flushSat),
    .id_ex_bubble(bubSat), .state(stateSat), .stall_cnt(cntSat)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] dst,
                               input logic br, input logic tk);
    idValid  = v;
    idRs     = rs;
    idRt     = rt;
    idUseRs  = urs;
    idUseRt  = urt;
    idDst    = dst;
    idBranch = br;
    exTaken  = tk;
  endtask

  task automatic pushExpected(input string tag, input int sel, input logic [1:0] st,
                              input logic pc, input logic fi, input logic fl,
                              input logic bub, input int cnt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.st = st; e.pc = pc;
    e.fi = fi; e.fl = fl; e.bub = bub; e.cnt = cnt;
    sbQ.push_back(e);
  endtask

  // Outputs are combinational, so they are compared 1 time unit after inputs settle.
  task automatic settleAndCheck;
    exp_t       e;
    logic [1:0] st;
    logic       pc, fi, fl, bub;
    int         cnt;
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("queueEmpty", 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      case (e.sel)
        0:       begin st = stateDef; pc = pcWeDef; fi = fiWeDef; fl = flushDef; bub = bubDef; cnt = int'(cntDef); end
        1:       begin st = stateNb;  pc = pcWeNb;  fi = fiWeNb;  fl = flushNb;  bub = bubNb;  cnt = int'(cntNb);  end
        default: begin st = stateSat; pc = pcWeSat; fi = fiWeSat; fl = flushSat; bub = bubSat; cnt = int'(cntSat); end
      endcase
      checkOutput({e.tag, ".state"}, 32'(st), 32'(e.st));
      checkOutput({e.tag, ".pc_we"}, 32'(pc), 32'(e.pc));
      checkOutput({e.tag, ".fi_id_we"}, 32'(fi), 32'(e.fi));
      checkOutput({e.tag, ".flush"}, 32'(fl), 32'(e.fl));
      checkOutput({e.tag, ".bubble"}, 32'(bub), 32'(e.bub));
      checkOutput({e.tag, ".stall_cnt"}, 32'(cnt), 32'(e.cnt));
    end
  endtask

  task automatic doCycle(input string tag, input int sel,
                         input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic br, input logic tk,
                         input logic [1:0] st, input logic pc, input logic fi,
                         input logic fl, input logic bub, input int cnt);
    applyStimulus(v, rs, rt, urs, urt, dst, br, tk);
    pushExpected(tag, sel, st, pc, fi, fl, bub, cnt);
    settleAndCheck();
    @(negedge CLK);
  endtask

  task automatic doReset;
    RST_N = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int stalls;
    logic haz;
    logic [1:0] st;

    RST_N = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    pushExpected("reset", 0, 2'd0, 1, 1, 0, 1, 0);
    settleAndCheck();
    @(negedge CLK);
    RST_N = 1'b1;

    // Back-to-back dependency on $3, WB bypass on: two stalls.
    doCycle("dep.wr",  0, 1, 0, 0, 0, 0, 3, 0, 0, 2'd0, 1, 1, 0, 0, 0);
    doCycle("dep.s1",  0, 1, 3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    doCycle("dep.s2",  0, 1, 3, 0, 1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1, 1);
    doCycle("dep.iss", 0, 1, 3, 0, 1, 0, 0, 0, 0, 2'd1, 1, 1, 0, 0, 2);
    // Register zero is never a dependency.
    doCycle("r0.wr",   0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2);
    doCycle("r0.rd",   0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2);
    // Taken branch; ex_taken high while issuing in RUN must be ignored.
    doCycle("tk.br",   0, 1, 0, 0, 0, 0, 0, 1, 1, 2'd0, 1, 1, 0, 0, 2);
    doCycle("tk.wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 1, 2);
    doCycle("tk.fl",   0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 1, 1, 1, 3);
    doCycle("tk.run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 1, 3);
    // Untaken branch, then a stray ex_taken pulse in RUN.
    doCycle("nt.br",   0, 1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 1, 0, 0, 3);
    doCycle("nt.wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 1, 3);
    doCycle("nt.pulse",0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1, 1, 0, 1, 4);
    doCycle("nt.run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 1, 4);
    // Hazarded branch on rt=5 waits, then issues exactly once.
    doCycle("hb.wr",   0, 1, 0, 0, 0, 0, 5, 0, 0, 2'd0, 1, 1, 0, 0, 4);
    doCycle("hb.s1",   0, 1, 0, 5, 0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 1, 4);
    doCycle("hb.s2",   0, 1, 0, 5, 0, 1, 0, 1, 0, 2'd1, 0, 0, 0, 1, 5);
    doCycle("hb.iss",  0, 1, 0, 5, 0, 1, 0, 1, 0, 2'd1, 1, 1, 0, 0, 6);
    doCycle("hb.wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 1, 6);
    doCycle("hb.run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 1, 7);

    // Asynchronous reset in BR_WAIT with a taken outcome pending.
    doCycle("rb.br",   0, 1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 1, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    pushExpected("rb.wait", 0, 2'd2, 0, 0, 0, 1, 7);
    settleAndCheck();
    #1 RST_N = 1'b0;
    pushExpected("rb.async", 0, 2'd0, 1, 1, 0, 1, 0);
    settleAndCheck();
    @(negedge CLK);
    RST_N = 1'b1;
    doCycle("rb.run1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1, 1, 0, 1, 0);
    doCycle("rb.run2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 1, 0);

    // Without WB bypass the same dependency costs three stalls.
    doReset();
    doCycle("nb.wr",  1, 1, 0, 0, 0, 0, 3, 0, 0, 2'd0, 1, 1, 0, 0, 0);
    doCycle("nb.s1",  1, 1, 3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    doCycle("nb.s2",  1, 1, 3, 0, 1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1, 1);
    doCycle("nb.s3",  1, 1, 3, 0, 1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1, 2);
    doCycle("nb.iss", 1, 1, 3, 0, 1, 0, 0, 0, 0, 2'd1, 1, 1, 0, 0, 3);
    doCycle("nb.run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 1, 3);

    // Self-dependent chain ($7 <- $7) gives 2 stalls per 3 cycles: 20 stalls in 30.
    doReset();
    stalls = 0;
    for (int k = 0; k < 30; k++) begin
      haz = (k % 3) != 0;
      st  = ((k % 3) == 1 || k == 0) ? 2'd0 : 2'd1;
      doCycle("sat", 2, 1, 7, 0, 1, 0, 7, 0, 0, st, !haz, !haz, 0, haz,
              (stalls > 15) ? 15 : stalls);
      if (haz) stalls++;
    end
    doCycle("sat.hold", 2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1, 1, 0, 1, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
